// File: rtl/wb_ctrl_pipe_if.sv
// wb_ctrl_pipe_if: decode inputs and W-stage/forwarding outputs of the write-back controller
interface wb_ctrl_pipe_if #(
  parameter int ADDR_W     = 5,
  parameter int PIPE_DEPTH = 1
);
  logic                         valid_in;
  logic [5:0]                   op;
  logic [5:0]                   funct;
  logic [ADDR_W-1:0]            rt;
  logic [ADDR_W-1:0]            rd;
  logic                         stall;
  logic                         flush;
  logic                         valid_out;
  logic                         reg_write;
  logic [1:0]                   reg_dst;
  logic [2:0]                   mem_to_reg;
  logic [2:0]                   load_ext;
  logic [ADDR_W-1:0]            wr_addr;
  logic [PIPE_DEPTH-1:0]        fwd_we;
  logic [PIPE_DEPTH*ADDR_W-1:0] fwd_addr;
  modport master (
    output valid_in, op, funct, rt, rd, stall, flush,
    input  valid_out, reg_write, reg_dst, mem_to_reg, load_ext, wr_addr, fwd_we, fwd_addr
  );
  modport slave (
    input  valid_in, op, funct, rt, rd, stall, flush,
    output valid_out, reg_write, reg_dst, mem_to_reg, load_ext, wr_addr, fwd_we, fwd_addr
  );
endinterface

// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: MIPS write-back control decode carried through PIPE_DEPTH stages with stall/flush.
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_ctrl_pipe #(
  parameter int ADDR_W     = 5,
  parameter int LINK_REG   = 31,
  parameter int PIPE_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_ctrl_pipe_if.slave     bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);
  typedef struct packed {
    logic              v;
    logic              we;
    logic [1:0]        dst;
    logic [2:0]        m2r;
    logic [2:0]        ext;
    logic [ADDR_W-1:0] wa;
  } stage_t;

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("wb_ctrl_pipe: PIPE_DEPTH must be 1..4");
  end

  logic       dec_we;
  logic [1:0] dec_dst;
  logic [2:0] dec_m2r;
  logic [2:0] dec_ext;
  stage_t     dec;
  stage_t [PIPE_DEPTH-1:0] pipe_d, pipe_q;
  stage_t     last;

  always_comb begin
    dec_we  = 1'b0;
    dec_dst = 2'd0;
    dec_m2r = 3'd0;
    dec_ext = 3'd0;
    case (bus.op)
      6'b001001, 6'b001011, 6'b001101: dec_we = 1'b1;
      6'b001111: begin dec_we = 1'b1; dec_m2r = 3'd2; end
      6'b100011: begin dec_we = 1'b1; dec_m2r = 3'd1; end
      6'b100000: begin dec_we = 1'b1; dec_m2r = 3'd1; dec_ext = 3'd1; end
      6'b100100: begin dec_we = 1'b1; dec_m2r = 3'd1; dec_ext = 3'd2; end
      6'b100001: begin dec_we = 1'b1; dec_m2r = 3'd1; dec_ext = 3'd3; end
      6'b100101: begin dec_we = 1'b1; dec_m2r = 3'd1; dec_ext = 3'd4; end
      6'b000011: begin dec_we = 1'b1; dec_dst = 2'd2; dec_m2r = 3'd3; end
      6'b000000:
        case (bus.funct)
          6'b001000, 6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_we = 1'b0;
          6'b001001: begin dec_we = 1'b1; dec_dst = 2'd1; dec_m2r = 3'd3; end
          6'b010000: begin dec_we = 1'b1; dec_dst = 2'd1; dec_m2r = 3'd4; end
          6'b010010: begin dec_we = 1'b1; dec_dst = 2'd1; dec_m2r = 3'd5; end
          default:   begin dec_we = 1'b1; dec_dst = 2'd1; end
        endcase
      default: dec_we = 1'b0;
    endcase
    dec.v   = bus.valid_in;
    dec.dst = dec_dst;
    dec.m2r = dec_m2r;
    dec.ext = dec_ext;
    dec.wa  = dec_dst == 2'd2 ? ADDR_W'(LINK_REG) : dec_dst == 2'd1 ? bus.rd : bus.rt;
    // $0 is hardwired, so a write to it is dropped here rather than at the register file
    dec.we  = dec_we && dec.wa != '0;
    if (!bus.valid_in) dec = '0;
  end

  always_comb begin
    pipe_d = pipe_q;
    if (bus.flush) pipe_d = '0;
    else if (!bus.stall) begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) pipe_d[i] = pipe_q[i-1];
      pipe_d[0] = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe_q <= '0;
    else pipe_q <= pipe_d;

  assign last           = pipe_q[PIPE_DEPTH-1];
  assign bus.valid_out  = last.v;
  assign bus.reg_write  = last.v & last.we;
  assign bus.reg_dst    = last.dst;
  assign bus.mem_to_reg = last.m2r;
  assign bus.load_ext   = last.ext;
  assign bus.wr_addr    = last.wa;

  always_comb begin
    bus.fwd_we   = '0;
    bus.fwd_addr = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      bus.fwd_we[i]                   = pipe_q[i].v & pipe_q[i].we;
      bus.fwd_addr[i*ADDR_W +: ADDR_W] = pipe_q[i].wa;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_d, retire_cnt_q;
  // an entry leaving the last stage retires even when flush kills the rest of the pipe
  always_comb retire_cnt_d = retire_cnt_q + {31'd0, last.v & ~bus.stall};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retire_cnt_q <= '0;
    else retire_cnt_q <= retire_cnt_d;
  assign retire_cnt = retire_cnt_q;
`endif
endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// tb_wb_ctrl_pipe: directed checks of wb_ctrl_pipe at PIPE_DEPTH=1 (decode) and 3 (pipeline)
module tb_wb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  wb_ctrl_pipe_if #(.ADDR_W(5), .PIPE_DEPTH(1)) b1();
  wb_ctrl_pipe_if #(.ADDR_W(5), .PIPE_DEPTH(3)) b3();
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] rc1, rc3;
`endif

  wb_ctrl_pipe #(.ADDR_W(5), .LINK_REG(31), .PIPE_DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(rc1)
`endif
  );
  wb_ctrl_pipe #(.ADDR_W(5), .LINK_REG(31), .PIPE_DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(rc3)
`endif
  );

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    logic       we;
    logic [1:0] dst;
    logic [2:0] m2r, ext;
    logic [4:0] wa;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input logic [5:0] o, f, input logic [4:0] t, d);
    b1.valid_in = v; b1.op = o; b1.funct = f; b1.rt = t; b1.rd = d;
  endtask

  task automatic drv3(input logic v, input logic [5:0] o, f, input logic [4:0] t, d);
    b3.valid_in = v; b3.op = o; b3.funct = f; b3.rt = t; b3.rd = d;
  endtask

  task automatic test_reset;
    logic [19:0] got1;
    logic [30:0] got3;
    drv1(0, 0, 0, 0, 0); b1.stall = 0; b1.flush = 0;
    drv3(0, 0, 0, 0, 0); b3.stall = 0; b3.flush = 0;
    #2;
    got1 = {b1.valid_out, b1.reg_write, b1.reg_dst, b1.mem_to_reg, b1.load_ext, b1.wr_addr, b1.fwd_we, b1.fwd_addr};
    got3 = {b3.valid_out, b3.reg_write, b3.reg_dst, b3.mem_to_reg, b3.load_ext, b3.wr_addr, b3.fwd_we, b3.fwd_addr};
    total++; if (got1 !== '0) begin bad++; $display("FAIL reset_d1 got=%h exp=0", got1); end
    total++; if (got3 !== '0) begin bad++; $display("FAIL reset_d3 got=%h exp=0", got3); end
    rst_n = 1'b1;
  endtask

  task automatic test_decode;
    vec_t tbl[23];
    logic [19:0] got, exp;
    tbl = '{
      '{"lw",     6'b100011, 6'd0,      5'd8,  5'd3, 1, 2'd0, 3'd1, 3'd0, 5'd8},
      '{"lb",     6'b100000, 6'd0,      5'd5,  5'd3, 1, 2'd0, 3'd1, 3'd1, 5'd5},
      '{"lbu",    6'b100100, 6'd0,      5'd6,  5'd3, 1, 2'd0, 3'd1, 3'd2, 5'd6},
      '{"lh",     6'b100001, 6'd0,      5'd7,  5'd3, 1, 2'd0, 3'd1, 3'd3, 5'd7},
      '{"lhu",    6'b100101, 6'd0,      5'd9,  5'd3, 1, 2'd0, 3'd1, 3'd4, 5'd9},
      '{"addiu",  6'b001001, 6'd0,      5'd10, 5'd3, 1, 2'd0, 3'd0, 3'd0, 5'd10},
      '{"sltiu",  6'b001011, 6'd0,      5'd11, 5'd3, 1, 2'd0, 3'd0, 3'd0, 5'd11},
      '{"ori",    6'b001101, 6'd0,      5'd12, 5'd3, 1, 2'd0, 3'd0, 3'd0, 5'd12},
      '{"lui",    6'b001111, 6'd0,      5'd13, 5'd3, 1, 2'd0, 3'd2, 3'd0, 5'd13},
      '{"jal",    6'b000011, 6'd0,      5'd2,  5'd3, 1, 2'd2, 3'd3, 3'd0, 5'd31},
      '{"sw",     6'b101011, 6'd0,      5'd4,  5'd5, 0, 2'd0, 3'd0, 3'd0, 5'd4},
      '{"beq",    6'b000100, 6'd0,      5'd4,  5'd5, 0, 2'd0, 3'd0, 3'd0, 5'd4},
      '{"j",      6'b000010, 6'd0,      5'd1,  5'd5, 0, 2'd0, 3'd0, 3'd0, 5'd1},
      '{"jr",     6'b000000, 6'b001000, 5'd2,  5'd3, 0, 2'd0, 3'd0, 3'd0, 5'd2},
      '{"jalr",   6'b000000, 6'b001001, 5'd2,  5'd7, 1, 2'd1, 3'd3, 3'd0, 5'd7},
      '{"mfhi",   6'b000000, 6'b010000, 5'd2,  5'd4, 1, 2'd1, 3'd4, 3'd0, 5'd4},
      '{"mflo",   6'b000000, 6'b010010, 5'd2,  5'd5, 1, 2'd1, 3'd5, 3'd0, 5'd5},
      '{"mult",   6'b000000, 6'b011000, 5'd2,  5'd6, 0, 2'd0, 3'd0, 3'd0, 5'd2},
      '{"divu",   6'b000000, 6'b011011, 5'd3,  5'd6, 0, 2'd0, 3'd0, 3'd0, 5'd3},
      '{"addu",   6'b000000, 6'b100001, 5'd2,  5'd9, 1, 2'd1, 3'd0, 3'd0, 5'd9},
      '{"unk",    6'b111111, 6'd0,      5'd0,  5'd4, 0, 2'd0, 3'd0, 3'd0, 5'd0},
      '{"addu_r0",6'b000000, 6'b100001, 5'd2,  5'd0, 0, 2'd1, 3'd0, 3'd0, 5'd0},
      '{"ori_r0", 6'b001101, 6'd0,      5'd0,  5'd7, 0, 2'd0, 3'd0, 3'd0, 5'd0}
    };
    foreach (tbl[k]) begin
      drv1(1, tbl[k].op, tbl[k].fn, tbl[k].rt, tbl[k].rd);
      tick;
      got = {b1.valid_out, b1.reg_write, b1.reg_dst, b1.mem_to_reg, b1.load_ext, b1.wr_addr, b1.fwd_we, b1.fwd_addr};
      exp = {1'b1, tbl[k].we, tbl[k].dst, tbl[k].m2r, tbl[k].ext, tbl[k].wa, tbl[k].we, tbl[k].wa};
      total++;
      if (got !== exp) begin bad++; $display("FAIL decode_%s got=%h exp=%h", tbl[k].name, got, exp); end
    end
    drv1(0, 6'b100011, 6'd0, 5'd8, 5'd8);
    tick;
    got = {b1.valid_out, b1.reg_write, b1.reg_dst, b1.mem_to_reg, b1.load_ext, b1.wr_addr, b1.fwd_we, b1.fwd_addr};
    total++; if (got !== '0) begin bad++; $display("FAIL bubble got=%h exp=0", got); end
  endtask

  task automatic test_pipe_stall;
    logic [22:0] got, exp;
    drv3(1, 6'b001101, 0, 5'd1, 0); tick;
    drv3(1, 6'b001101, 0, 5'd2, 0); tick;
    got = {b3.valid_out, b3.fwd_we, 4'd0, b3.fwd_addr};
    exp = {1'b0, 3'b011, 4'd0, 5'd0, 5'd1, 5'd2};
    total++; if (got !== exp) begin bad++; $display("FAIL pipe_e2 got=%h exp=%h", got, exp); end
    drv3(1, 6'b001101, 0, 5'd3, 0); tick;
    exp = {1'b1, 3'b111, 4'd1, 5'd1, 5'd2, 5'd3};
    got = {b3.reg_write, b3.fwd_we, b3.wr_addr[3:0], b3.fwd_addr};
    total++; if (got !== exp) begin bad++; $display("FAIL pipe_e3 got=%h exp=%h", got, exp); end
    drv3(0, 0, 0, 0, 0); b3.stall = 1;
    for (int s = 0; s < 2; s++) begin
      tick;
      got = {b3.reg_write, b3.fwd_we, b3.wr_addr[3:0], b3.fwd_addr};
      total++; if (got !== exp) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", s, got, exp); end
    end
    b3.stall = 0; tick;
    got = {b3.reg_write, b3.fwd_we, b3.wr_addr[3:0], b3.fwd_addr};
    exp = {1'b1, 3'b110, 4'd2, 5'd2, 5'd3, 5'd0};
    total++; if (got !== exp) begin bad++; $display("FAIL pipe_resume got=%h exp=%h", got, exp); end
    tick;
    got = {b3.reg_write, b3.fwd_we, b3.wr_addr[3:0], b3.fwd_addr};
    exp = {1'b1, 3'b100, 4'd3, 5'd3, 5'd0, 5'd0};
    total++; if (got !== exp) begin bad++; $display("FAIL pipe_last got=%h exp=%h", got, exp); end
    tick;
    total++; if (b3.valid_out !== 1'b0) begin bad++; $display("FAIL pipe_drain got=%b exp=0", b3.valid_out); end
  endtask

  task automatic test_flush;
    logic [23:0] got;
    for (int n = 4; n < 7; n++) begin drv3(1, 6'b001101, 0, 5'(n), 0); tick; end
    total++; if (b3.fwd_we !== 3'b111) begin bad++; $display("FAIL flush_fill got=%b exp=111", b3.fwd_we); end
    drv3(1, 6'b001101, 0, 5'd7, 0); b3.flush = 1; b3.stall = 1; tick;
    got = {b3.valid_out, b3.reg_write, b3.fwd_we, b3.fwd_addr, b3.wr_addr};
    total++; if (got !== '0) begin bad++; $display("FAIL flush_over_stall got=%h exp=0", got); end
    b3.flush = 0; b3.stall = 0; drv3(0, 0, 0, 0, 0); tick;
    got = {b3.valid_out, b3.reg_write, b3.fwd_we, b3.fwd_addr, b3.wr_addr};
    total++; if (got !== '0) begin bad++; $display("FAIL flush_after got=%h exp=0", got); end
  endtask

  task automatic test_reset_midstream;
    logic [23:0] got;
    for (int n = 1; n < 4; n++) begin drv3(1, 6'b001101, 0, 5'(n), 0); tick; end
    drv3(1, 6'b001101, 0, 5'd9, 0);
    #2 rst_n = 0;
    #1;
    got = {b3.valid_out, b3.reg_write, b3.fwd_we, b3.fwd_addr, b3.wr_addr};
    total++; if (got !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", got); end
    #1 rst_n = 1;
    for (int e = 1; e <= 3; e++) begin
      tick;
      total++;
      if (b3.valid_out !== (e == 3)) begin bad++; $display("FAIL post_reset_e%0d got=%b exp=%b", e, b3.valid_out, e == 3); end
    end
    total++; if (b3.wr_addr !== 5'd9) begin bad++; $display("FAIL post_reset_addr got=%0d exp=9", b3.wr_addr); end
    drv3(0, 0, 0, 0, 0);
    repeat (3) tick;
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire;
    logic [1:0] seq[7];
    seq = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10};
    #2 rst_n = 0;
    #1 rst_n = 1;
    foreach (seq[k]) begin
      drv3(seq[k][1], 6'b001101, 0, 5'(k + 1), 0); b3.stall = seq[k][0]; tick;
    end
    drv3(0, 0, 0, 0, 0); b3.stall = 0;
    repeat (4) tick;
    total++; if (rc3 !== 32'd5) begin bad++; $display("FAIL retire_cnt got=%0d exp=5", rc3); end
    drv1(1, 6'b001101, 0, 5'd1, 0);
    force u1.retire_cnt_q = 32'hFFFF_FFFE;
    #1 release u1.retire_cnt_q;
    tick;
    tick;
    total++; if (rc1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL retire_max got=%h exp=ffffffff", rc1); end
    tick;
    total++; if (rc1 !== 32'd0) begin bad++; $display("FAIL retire_wrap got=%h exp=0", rc1); end
    drv1(0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset;
    test_decode;
    test_pipe_stall;
    test_flush;
    test_reset_midstream;
`ifdef WB_RETIRE_CNT_EN
    test_retire;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
